// File: rtl/go_display_ctrl_pkg.sv
// Shared constants, FSM state type and the double-dabble step helper for the
// Go Board display controller.
package go_display_pkg;

    localparam logic [15:0] VALUE_OFS = 16'd0;
    localparam logic [15:0] CTRL_OFS  = 16'd1;

    localparam int unsigned CTRL_DEC   = 32'd0;
    localparam int unsigned CTRL_BLANK = 32'd1;
    localparam int unsigned CTRL_BLINK = 32'd2;

    localparam int unsigned DD_ITERS = 32'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } ddState_e;

    // One double-dabble iteration on {hundreds, tens, units, binary}: adjust each
    // BCD nibble that is 5 or more, then shift the whole scratch left by one.
    function automatic logic [19:0] ddStep(input logic [19:0] scratch);
        logic [19:0] adj;
        adj = scratch;
        for (int n = 0; n < 3; n++) begin
            if (adj[8 + 4*n +: 4] >= 4'd5) begin
                adj[8 + 4*n +: 4] = adj[8 + 4*n +: 4] + 4'd3;
            end else begin
                adj[8 + 4*n +: 4] = adj[8 + 4*n +: 4];
            end
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/go_display_ctrl_if.sv
// Write-only cpu16 bus slice seen by the display controller.
interface go_display_bus_if;
    logic        wr_en;
    logic [15:0] addr;
    logic [15:0] wr_data;

    modport master (output wr_en, output addr, output wr_data);
    modport slave  (input wr_en, input addr, input wr_data);
endinterface

// File: rtl/go_display_ctrl_bin2bcd_seq.sv
// 8-bit sequential double-dabble: start loads, DD_ITERS shift cycles, one
// COMMIT cycle with done high while bcd holds the final three digits.
module bin2bcd_seq
    import go_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    localparam logic [2:0] LAST_ITER = 3'(DD_ITERS - 1);

    ddState_e    stateR;
    logic [19:0] scratchR;
    logic [2:0]  iterR;

    assign bcd = scratchR[19:8];

    // Conversion FSM; start wins over abort so a restart never commits stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateR   <= IDLE;
            scratchR <= 20'd0;
            iterR    <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            stateR   <= SHIFT;
            scratchR <= {12'd0, bin};
            iterR    <= 3'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (abort) begin
            stateR <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                SHIFT: begin
                    scratchR <= ddStep(scratchR);
                    iterR    <= iterR + 3'd1;
                    if (iterR == LAST_ITER) begin
                        stateR <= COMMIT;
                        done   <= 1'b1;
                    end else begin
                        done <= 1'b0;
                    end
                end
                COMMIT: begin
                    stateR <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
                default: begin
                    stateR <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/go_display_ctrl.sv
// Display register for the two seven-segment digits: VALUE/CTRL decode, hex or
// decimal digit muxing. Optional blinking is built when GO_DISPLAY_BLINK_EN is defined.
module go_display_ctrl
    import go_display_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int unsigned BLINK_DIV = 32'd12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    go_display_bus_if.slave  bus,
    output logic [3:0]       digit_hi,
    output logic [3:0]       digit_lo,
    output logic             blank,
    output logic             busy,
    output logic             ovf
);

    logic [7:0]  valueR;
    logic [2:0]  ctrlR;
    logic        valueWrS;
    logic        ctrlWrS;
    logic [7:0]  nextValueS;
    logic [2:0]  nextCtrlS;
    logic        startS;
    logic        abortS;
    logic        commitS;
    logic        convDoneS;
    logic [11:0] bcdS;
    logic        blinkMaskS;

    // Write decode and conversion triggers (VALUE write in decimal mode, or DEC rising).
    always_comb begin
        valueWrS   = bus.wr_en && (bus.addr == (BASE_ADDR + VALUE_OFS));
        ctrlWrS    = bus.wr_en && (bus.addr == (BASE_ADDR + CTRL_OFS));
        nextValueS = valueWrS ? bus.wr_data[7:0] : valueR;
        nextCtrlS  = ctrlWrS ? bus.wr_data[2:0] : ctrlR;
        startS     = nextCtrlS[CTRL_DEC] && (valueWrS || (ctrlWrS && !ctrlR[CTRL_DEC]));
        abortS     = ctrlWrS && ctrlR[CTRL_DEC] && !nextCtrlS[CTRL_DEC];
        commitS    = ctrlR[CTRL_DEC] && convDoneS && !startS && !abortS;
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (startS),
        .abort (abortS),
        .bin   (nextValueS),
        .busy  (busy),
        .done  (convDoneS),
        .bcd   (bcdS)
    );

    // Registers and output muxing; decimal digits only change on a clean commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valueR   <= 8'd0;
            ctrlR    <= 3'd0;
            digit_hi <= 4'd0;
            digit_lo <= 4'd0;
            blank    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            valueR <= nextValueS;
            ctrlR  <= nextCtrlS;
            blank  <= ctrlR[CTRL_BLANK] | blinkMaskS;
            if (!ctrlR[CTRL_DEC]) begin
                digit_hi <= valueR[7:4];
                digit_lo <= valueR[3:0];
                ovf      <= 1'b0;
            end else if (commitS) begin
                digit_hi <= bcdS[7:4];
                digit_lo <= bcdS[3:0];
                ovf      <= (bcdS[11:8] != 4'd0);
            end
        end
    end

`ifdef GO_DISPLAY_BLINK_EN
    localparam int unsigned CNT_W = (BLINK_DIV > 32'd1) ? $clog2(BLINK_DIV) : 32'd1;

    logic [CNT_W-1:0] blinkCntR;
    logic             blinkPhaseR;
    logic             unusedBits;

    assign blinkMaskS = ctrlR[CTRL_BLINK] & blinkPhaseR;
    assign unusedBits = ^bus.wr_data[15:8];

    // Half-period counter; a CTRL write restarts it so blinking begins visible.
    always_ff @(posedge clk) begin
        if (!rst_n || ctrlWrS) begin
            blinkCntR   <= '0;
            blinkPhaseR <= 1'b0;
        end else if (blinkCntR == CNT_W'(BLINK_DIV - 32'd1)) begin
            blinkCntR   <= '0;
            blinkPhaseR <= ~blinkPhaseR;
        end else begin
            blinkCntR <= blinkCntR + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unusedBits;

    assign blinkMaskS = 1'b0;
    assign unusedBits = ^{bus.wr_data[15:8], ctrlR[CTRL_BLINK], BLINK_DIV[0]};
`endif

endmodule

// File: tb/tb_go_display_ctrl.sv
// Directed self-checking bench for go_display_ctrl (hex, decimal, restart,
// abort, reset, blank and blink behaviour).
module tb_go_display_ctrl;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] CTRL = 16'hFF01;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;
    logic       blank;
    logic       busy;
    logic       ovf;
    int         nCmp;
    int         nErr;

    go_display_bus_if busIf ();

    go_display_ctrl #(
        .BASE_ADDR (BASE),
        .BLINK_DIV (32'd4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (busIf),
        .digit_hi (digit_hi),
        .digit_lo (digit_lo),
        .blank    (blank),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
        busIf.wr_en   = 1'b1;
        busIf.addr    = a;
        busIf.wr_data = d;
        tick();
        busIf.wr_en   = 1'b0;
        busIf.addr    = 16'h0000;
        busIf.wr_data = 16'h0000;
    endtask

    task automatic checkOut(input string tag, input logic [3:0] hi, input logic [3:0] lo,
                            input logic bz, input logic ov);
        check({tag, "_hi"}, {4'd0, digit_hi}, {4'd0, hi});
        check({tag, "_lo"}, {4'd0, digit_lo}, {4'd0, lo});
        check({tag, "_busy"}, {7'd0, busy}, {7'd0, bz});
        check({tag, "_ovf"}, {7'd0, ovf}, {7'd0, ov});
    endtask

    // Decimal conversion: busy after the write edge, result nine edges later.
    task automatic convert(input string tag, input logic [7:0] v,
                           input logic [3:0] hi, input logic [3:0] lo, input logic ov);
        busWrite(BASE, {8'd0, v});
        check({tag, "_busy_start"}, {7'd0, busy}, 8'd1);
        repeat (8) tick();
        check({tag, "_busy_last"}, {7'd0, busy}, 8'd1);
        tick();
        checkOut(tag, hi, lo, 1'b0, ov);
    endtask

    initial begin
        nCmp          = 0;
        nErr          = 0;
        rst_n         = 1'b0;
        busIf.wr_en   = 1'b0;
        busIf.addr    = 16'h0000;
        busIf.wr_data = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        checkOut("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        check("reset_blank", {7'd0, blank}, 8'd0);

        // Hex mode, 1-cycle latency.
        busWrite(BASE, 16'h003C);
        tick();
        checkOut("hex3C", 4'h3, 4'hC, 1'b0, 1'b0);

        // DEC rising converts current value 0x3C = 60; digits hold during conversion.
        busWrite(CTRL, 16'h0001);
        checkOut("dec_on_hold", 4'h3, 4'hC, 1'b1, 1'b0);
        repeat (8) tick();
        checkOut("dec_on_hold8", 4'h3, 4'hC, 1'b1, 1'b0);
        tick();
        checkOut("dec60", 4'h6, 4'h0, 1'b0, 1'b0);

        // VALUE=87: busy exactly 9 cycles, previous digits held.
        busWrite(BASE, 16'd87);
        for (int i = 0; i < 9; i++) begin
            checkOut("dec87_hold", 4'h6, 4'h0, 1'b1, 1'b0);
            tick();
        end
        checkOut("dec87", 4'h8, 4'h7, 1'b0, 1'b0);

        convert("dec200", 8'd200, 4'h0, 4'h0, 1'b1);
        convert("dec255", 8'd255, 4'h5, 4'h5, 1'b1);
        convert("dec100", 8'd100, 4'h0, 4'h0, 1'b1);
        convert("dec0", 8'd0, 4'h0, 4'h0, 1'b0);
        convert("dec99", 8'd99, 4'h9, 4'h9, 1'b0);

        // Restart: 42 then 17 four cycles later; 4,2 must never appear.
        busWrite(BASE, 16'd42);
        for (int i = 0; i < 3; i++) begin
            checkOut("restart_hold_a", 4'h9, 4'h9, 1'b1, 1'b0);
            tick();
        end
        busWrite(BASE, 16'd17);
        for (int i = 0; i < 9; i++) begin
            checkOut("restart_hold_b", 4'h9, 4'h9, 1'b1, 1'b0);
            tick();
        end
        checkOut("dec17", 4'h1, 4'h7, 1'b0, 1'b0);

        // Reset during SHIFT aborts with no later commit.
        busWrite(BASE, 16'd55);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOut("rst_mid", 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (12) tick();
        checkOut("rst_nocommit", 4'h0, 4'h0, 1'b0, 1'b0);

        // BLANK bit, 1-cycle latency.
        busWrite(CTRL, 16'h0002);
        check("blank_pre", {7'd0, blank}, 8'd0);
        tick();
        check("blank_on", {7'd0, blank}, 8'd1);

        // DEC off while busy aborts; hex nibbles of 77 (0x4D) after the next edge.
        busWrite(CTRL, 16'h0001);
        tick();
        busWrite(BASE, 16'd77);
        tick();
        busWrite(CTRL, 16'h0000);
        check("abort_busy", {7'd0, busy}, 8'd0);
        tick();
        checkOut("abort_hex", 4'h4, 4'hD, 1'b0, 1'b0);
        check("abort_blank", {7'd0, blank}, 8'd0);

        // Hex boundary 0xFF.
        busWrite(BASE, 16'h00FF);
        tick();
        checkOut("hexFF", 4'hF, 4'hF, 1'b0, 1'b0);

        // BLINK bit: toggles every 4 cycles when built in, otherwise ignored.
        busWrite(CTRL, 16'h0004);
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef GO_DISPLAY_BLINK_EN
            check("blink", {7'd0, blank}, 8'(((k - 1) / 4) % 2));
`else
            check("blink_off", {7'd0, blank}, 8'd0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
